simmem_linkedlist_delay_writer: RTL and testbench
=================================================

// Module: simmem_linkedlist_delay_writer
// PURPOSE
// Enqueue side of the per-ID delay linked-list bank in the simulated memory controller.
// - Accepts (ID, delay) entries over a valid/ready handshake.
// - Stores each entry in a shared slot RAM and appends it to that ID's linked list.
// - Presents the head delay of every ID to the release/reduction logic.
// - Frees head slots when that logic returns a release one-hot.
// PARAMETERS
// IDWidth     4   width of message identifier; 2**IDWidth independent lists
// DelayWidth  16  width of a stored delay value
// NumSlots    16  shared slot count; PtrWidth = $clog2(NumSlots); must be >= 2
// PORTS
// clk_i             in   1                     clock
// rst_i             in   1                     synchronous, active-high reset
// in_id_i           in   IDWidth               ID of incoming entry
// in_delay_i        in   DelayWidth            delay of incoming entry
// in_valid_i        in   1                     incoming entry valid
// in_ready_o        out  1                     free slot available
// release_onehot_i  in   2**IDWidth            per-ID pop request for the head entry
// head_delay_o      out  DelayWidth x 2**IDWidth  unpacked; head delay per ID, 0 when empty
// head_valid_o      out  2**IDWidth            per-ID list non-empty
// occupancy_o       out  PtrWidth+1            number of allocated slots
// BEHAVIOUR
// - Reset, single clock, synchronous active-high: one cycle of rst_i high produces:
//   all lists empty, all slots free, occupancy_o=0, head_valid_o=0, head_delay_o=0, in_ready_o=1.
// - Reset mid-operation discards all stored entries; no outputs are held over.
// - State:
//   - slot RAM data[NumSlots], next[NumSlots]
//   - free bitmap
//   - per-ID head_ptr, tail_ptr, nonempty flag
// - in_ready_o = (occupancy_o != NumSlots).
//   - Driven only from registered state.
//   - Never combinationally dependent on in_valid_i or release_onehot_i.
// - Enqueue (in_valid_i && in_ready_o): allocate the lowest-index free slot from the pre-cycle bitmap.
//   - data[s] <= in_delay_i.
//   - If the ID list is empty (after this cycle's release): head=tail=s.
//   - Otherwise next[tail] <= s and tail <= s.
// - Release: for each i with release_onehot_i[i] && head_valid_o[i]:
//   - free slot head_ptr[i].
//   - If head_ptr[i]==tail_ptr[i], the list becomes empty.
//   - Otherwise head_ptr[i] <= next[head_ptr[i]].
//   - Release bits for empty IDs are ignored (no state change).
//   - Multiple bits may be set; each ID is handled independently in the same cycle.
// - Latency:
//   - An entry enqueued into an empty list appears on head_delay_o/head_valid_o the next cycle.
//   - A released head is replaced by its successor the next cycle.
//   - head_delay_o = data[head_ptr] when valid, else 0; a combinational read of registered state.
// - Simultaneous enqueue and release, same ID:
//   - Single-entry list: the new entry becomes head and tail.
//   - Multi-entry list: append to the old tail and pop the old head, both in that cycle.
// - Slot freed this cycle is not allocatable until the next cycle.
//   - When full, a same-cycle release does not raise in_ready_o until the next cycle.
// - occupancy_o: +1 per accepted enqueue, minus the number of effective releases, same cycle.
//   - Never exceeds NumSlots; never underflows.
// - Per-ID FIFO order is preserved; different IDs share slots with no ordering between them.
// - Assertions:
//   - in_id_i stable while in_valid_i && !in_ready_o.
//   - Free bitmap popcount == NumSlots - occupancy_o.
// TESTING
// 1. Reset, then enqueue (id3,d=5) -> next cycle head_valid_o[3]=1, head_delay_o[3]=5, occupancy_o=1, others 0.
// 2. Enqueue id2 delays 7,9,11 back-to-back, release id2 three times ->
//    head_delay_o[2] shows 7,9,11 then head_valid_o[2]=0; occupancy_o back to 0.
// 3. Fill all 16 slots across IDs -> in_ready_o=0.
//    Release one head and present a new entry the same cycle -> not accepted; accepted the cycle after.
// 4. id5 holds one entry (d=4); same cycle release id5 and enqueue id5 d=8 ->
//    next cycle head_valid_o[5]=1, head_delay_o[5]=8, occupancy_o unchanged.
// 5. release_onehot_i=16'hFFFF with only id0 and id1 non-empty -> only those pop;
//    occupancy_o -2; no other state changes.
// 6. Assert rst_i with 10 entries stored -> next cycle all head_valid_o=0, occupancy_o=0, in_ready_o=1.

Source files
------------

// File: rtl/simmem_linkedlist_delay_writer.sv
// Enqueue side of the per-ID delay linked-list bank.
// Entries share one slot RAM; each ID threads its own FIFO through it.
module simmem_linkedlist_delay_writer #(
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 16,
  parameter int NumSlots   = 16,
  localparam int NumIds    = 2 ** IDWidth,
  localparam int PtrWidth  = $clog2(NumSlots)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDWidth-1:0]    in_id_i,
  input  logic [DelayWidth-1:0] in_delay_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NumIds-1:0]     release_onehot_i,
  output logic [DelayWidth-1:0] head_delay_o [NumIds],
  output logic [NumIds-1:0]     head_valid_o,
  output logic [PtrWidth:0]     occupancy_o
);

  localparam logic [PtrWidth:0] FullCnt = (PtrWidth + 1)'(NumSlots);

  logic [DelayWidth-1:0] data_q [NumSlots];
  logic [PtrWidth-1:0]   next_q [NumSlots];
  logic [NumSlots-1:0]   free_q;
  logic [PtrWidth-1:0]   head_q [NumIds];
  logic [PtrWidth-1:0]   tail_q [NumIds];
  logic [NumIds-1:0]     nonempty_q;
  logic [PtrWidth:0]     occ_q;

  logic [PtrWidth-1:0]   alloc;
  logic                  alloc_ok;
  logic                  enq;
  logic [NumIds-1:0]     rel;
  logic [NumIds-1:0]     empty_after;
  logic [PtrWidth:0]     rel_cnt;
  logic [PtrWidth:0]     occ_d;

  assign in_ready_o  = (occ_q != FullCnt);
  assign occupancy_o = occ_q;

  always_comb begin
    alloc    = '0;
    alloc_ok = 1'b0;
    for (int s = NumSlots - 1; s >= 0; s--) begin
      if (free_q[s]) begin
        alloc    = PtrWidth'(s);
        alloc_ok = 1'b1;
      end
    end
  end

  assign enq = in_valid_i && in_ready_o && alloc_ok;
  assign rel = release_onehot_i & nonempty_q;

  // A list drained this cycle takes a same-cycle enqueue as a fresh head.
  always_comb begin
    empty_after = '0;
    rel_cnt     = '0;
    for (int i = 0; i < NumIds; i++) begin
      empty_after[i] = !nonempty_q[i] ||
                       (rel[i] && head_q[i] == tail_q[i]);
      rel_cnt = rel_cnt + (PtrWidth + 1)'(rel[i]);
    end
  end

  assign occ_d = occ_q + (PtrWidth + 1)'(enq) - rel_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q     <= '1;
      nonempty_q <= '0;
      occ_q      <= '0;
      head_q     <= '{default: '0};
      tail_q     <= '{default: '0};
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < NumIds; i++) begin
        if (rel[i]) begin
          free_q[head_q[i]] <= 1'b1;
          if (head_q[i] == tail_q[i]) begin
            nonempty_q[i] <= 1'b0;
          end else begin
            head_q[i] <= next_q[head_q[i]];
          end
        end
      end
      if (enq) begin
        free_q[alloc] <= 1'b0;
        tail_q[in_id_i] <= alloc;
        if (empty_after[in_id_i]) begin
          head_q[in_id_i]     <= alloc;
          nonempty_q[in_id_i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq && !rst_i) begin
      data_q[alloc] <= in_delay_i;
      if (!empty_after[in_id_i]) begin
        next_q[tail_q[in_id_i]] <= alloc;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      head_valid_o[i] = nonempty_q[i];
      head_delay_o[i] = nonempty_q[i] ? data_q[head_q[i]] : '0;
    end
  end

  a_id_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (in_valid_i && !in_ready_o) |=> (!in_valid_i || $stable(in_id_i))
  );

  a_free_count: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $countones(free_q) == (NumSlots - int'(occ_q))
  );

endmodule

// File: tb/tb_simmem_linkedlist_delay_writer.sv
// Directed bench for the linked-list delay writer.
// Each task drives one scenario and checks hand-computed values.
module tb_simmem_linkedlist_delay_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_id = '0;
  logic [15:0] in_delay = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] rel_oh = '0;
  logic [15:0] head_delay [16];
  logic [15:0] head_valid;
  logic [4:0]  occ;

  int checks = 0;
  int errors = 0;

  simmem_linkedlist_delay_writer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_id_i          (in_id),
    .in_delay_i       (in_delay),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .release_onehot_i (rel_oh),
    .head_delay_o     (head_delay),
    .head_valid_o     (head_valid),
    .occupancy_o      (occ)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [3:0] id, input logic [15:0] d);
    in_valid = 1'b1;
    in_id    = id;
    in_delay = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 16; i++) if (head_delay[i] !== 16'd0) nz++;
    checks++;
    if (occ !== 5'd0) begin
      errors++;
      $display("FAIL %s_occ got %0d exp 0", tag, occ);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b exp 1", tag, in_ready);
    end
    checks++;
    if (head_valid !== 16'h0000) begin
      errors++;
      $display("FAIL %s_hvalid got %h exp 0000", tag, head_valid);
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL %s_hdelay nonzero_count %0d exp 0", tag, nz);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    check_idle("reset");
  endtask

  task automatic test_single;
    int nz;
    enqueue(4'd3, 16'd5);
    checks++;
    if (head_valid !== 16'h0008) begin
      errors++;
      $display("FAIL single_hvalid got %h exp 0008", head_valid);
    end
    checks++;
    if (head_delay[3] !== 16'd5) begin
      errors++;
      $display("FAIL single_hdelay got %0d exp 5", head_delay[3]);
    end
    checks++;
    if (occ !== 5'd1) begin
      errors++;
      $display("FAIL single_occ got %0d exp 1", occ);
    end
    nz = 0;
    for (int i = 0; i < 16; i++) if (i != 3 && head_delay[i] !== 16'd0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL single_others nonzero_count %0d exp 0", nz);
    end
    rel_oh = 16'h0008;
    tick();
    rel_oh = '0;
    check_idle("single_pop");
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'd9;
    exp_d[1] = 16'd11;
    exp_d[2] = 16'd0;
    in_valid = 1'b1;
    in_id    = 4'd2;
    in_delay = 16'd7;
    tick();
    in_delay = 16'd9;
    tick();
    in_delay = 16'd11;
    tick();
    in_valid = 1'b0;
    checks++;
    if (head_delay[2] !== 16'd7 || occ !== 5'd3) begin
      errors++;
      $display("FAIL b2b_fill got d=%0d occ=%0d exp d=7 occ=3",
               head_delay[2], occ);
    end
    rel_oh = 16'h0004;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (head_delay[2] !== exp_d[k] || occ !== 5'(2 - k)) begin
        errors++;
        $display("FAIL b2b_pop%0d got d=%0d occ=%0d exp d=%0d occ=%0d",
                 k, head_delay[2], occ, exp_d[k], 2 - k);
      end
    end
    rel_oh = '0;
    checks++;
    if (head_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got %b exp 0", head_valid[2]);
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) enqueue(4'(i % 4), 16'(100 + i));
    checks++;
    if (in_ready !== 1'b0 || occ !== 5'd16) begin
      errors++;
      $display("FAIL full_state got rdy=%b occ=%0d exp rdy=0 occ=16",
               in_ready, occ);
    end
    checks++;
    if (head_delay[1] !== 16'd101 || head_delay[3] !== 16'd103) begin
      errors++;
      $display("FAIL full_heads got %0d,%0d exp 101,103",
               head_delay[1], head_delay[3]);
    end
    rel_oh   = 16'h0001;
    in_valid = 1'b1;
    in_id    = 4'd9;
    in_delay = 16'd55;
    tick();
    rel_oh = '0;
    checks++;
    if (occ !== 5'd15 || head_valid[9] !== 1'b0) begin
      errors++;
      $display("FAIL full_blocked got occ=%0d v9=%b exp occ=15 v9=0",
               occ, head_valid[9]);
    end
    checks++;
    if (head_delay[0] !== 16'd104 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got d0=%0d rdy=%b exp d0=104 rdy=1",
               head_delay[0], in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (head_valid[9] !== 1'b1 || head_delay[9] !== 16'd55) begin
      errors++;
      $display("FAIL full_accept got v9=%b d9=%0d exp v9=1 d9=55",
               head_valid[9], head_delay[9]);
    end
    checks++;
    if (occ !== 5'd16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refill got occ=%0d rdy=%b exp occ=16 rdy=0",
               occ, in_ready);
    end
    do_reset();
  endtask

  task automatic test_same_id;
    enqueue(4'd5, 16'd4);
    rel_oh = 16'h0020;
    enqueue(4'd5, 16'd8);
    rel_oh = '0;
    checks++;
    if (head_valid[5] !== 1'b1 || head_delay[5] !== 16'd8 || occ !== 5'd1) begin
      errors++;
      $display("FAIL same1 got v=%b d=%0d occ=%0d exp v=1 d=8 occ=1",
               head_valid[5], head_delay[5], occ);
    end
    enqueue(4'd5, 16'd12);
    rel_oh = 16'h0020;
    enqueue(4'd5, 16'd20);
    checks++;
    if (head_delay[5] !== 16'd12 || occ !== 5'd2) begin
      errors++;
      $display("FAIL same_multi got d=%0d occ=%0d exp d=12 occ=2",
               head_delay[5], occ);
    end
    tick();
    checks++;
    if (head_delay[5] !== 16'd20 || occ !== 5'd1) begin
      errors++;
      $display("FAIL same_tail got d=%0d occ=%0d exp d=20 occ=1",
               head_delay[5], occ);
    end
    tick();
    rel_oh = '0;
    check_idle("same_drain");
  endtask

  task automatic test_release_all;
    enqueue(4'd0, 16'd1);
    enqueue(4'd1, 16'd2);
    enqueue(4'd1, 16'd3);
    rel_oh = 16'hFFFF;
    tick();
    rel_oh = '0;
    checks++;
    if (head_valid !== 16'h0002 || occ !== 5'd1) begin
      errors++;
      $display("FAIL relall got v=%h occ=%0d exp v=0002 occ=1",
               head_valid, occ);
    end
    checks++;
    if (head_delay[1] !== 16'd3 || head_delay[0] !== 16'd0) begin
      errors++;
      $display("FAIL relall_d got d1=%0d d0=%0d exp d1=3 d0=0",
               head_delay[1], head_delay[0]);
    end
    rel_oh = 16'hFFFF;
    tick();
    rel_oh = '0;
    check_idle("relall_drain");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 10; i++) enqueue(4'(i), 16'(i + 1));
    checks++;
    if (occ !== 5'd10 || head_valid !== 16'h03FF || head_delay[9] !== 16'd10) begin
      errors++;
      $display("FAIL mid_fill got occ=%0d v=%h d9=%0d exp occ=10 v=03ff d9=10",
               occ, head_valid, head_delay[9]);
    end
    do_reset();
    check_idle("mid_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_same_id();
    test_release_all();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
